conv_result_writer: RTL and testbench
=====================================

// Module: conv_result_writer
// PURPOSE
//  Downstream stage of the DSP-cascade PE. Captures the PE result stream (o_en/o_P),
//  then arithmetic-shifts, optionally ReLUs and saturates each result into the output
//  feature-map buffer. Once all OUT_DIM*OUT_DIM results are in, it streams them out in
//  raster order over a valid/ready port to the next layer or the host.
// PARAMETERS
//  KERNEL_SIZE  3   kernel edge; must match the PE instance
//  FM_SIZE      4   input feature-map edge; must match the PE instance
//  PADDING      0   zero padding; must match the PE instance
//  STRIDE       1   convolution stride; must match the PE instance
//  IN_WIDTH     48  PE accumulator width (signed)
//  OUT_WIDTH    16  stored/streamed result width (signed)
//  SHIFT        0   arithmetic right shift applied before saturation (0..IN_WIDTH-1)
//  derived: OUT_DIM=(FM_SIZE-KERNEL_SIZE+2*PADDING)/STRIDE+1, N_OUT=OUT_DIM*OUT_DIM
// PORTS
//  i_clk        in   1          single clock, rising edge
//  i_rst_n      in   1          asynchronous active-low reset
//  i_start      in   1          arm a new collection; sampled only in IDLE
//  i_relu_en    in   1          1: clamp negative results to 0; sampled on i_start
//  i_en         in   1          result valid from PE (PE o_en)
//  i_P          in   IN_WIDTH   signed result from PE (PE o_P)
//  i_rd_ready   in   1          downstream ready
//  o_rd_valid   out  1          output word valid
//  o_rd_data    out  OUT_WIDTH  signed output word
//  o_rd_row     out  clog2(OUT_DIM) row index of o_rd_data
//  o_rd_col     out  clog2(OUT_DIM) column index of o_rd_data
//  o_busy       out  1          high in COLLECT and DRAIN
//  o_done       out  1          one-cycle pulse after the last word is accepted
//  o_overflow   out  1          sticky: i_en seen outside COLLECT; cleared by i_start
// BEHAVIOUR
//  Reset: state=IDLE; all counters 0; o_rd_valid, o_rd_data, o_rd_row, o_rd_col,
//   o_busy, o_done, o_overflow=0. Buffer contents are undefined.
//  FSM IDLE->COLLECT on i_start (wr_cnt:=0, o_overflow:=0, latch i_relu_en).
//  COLLECT: each cycle with i_en=1, process i_P and register it (1-cycle pipe). The
//   word is written to buf[wr_cnt] on the next edge, then wr_cnt++.
//   After the N_OUT-th write -> DRAIN. i_start is ignored.
//  Processing: s=i_P>>>SHIFT (floor). If ReLU is latched and s<0, s=0.
//   Saturate s to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//  DRAIN: rd_cnt walks 0..N_OUT-1. o_rd_valid rises the cycle after DRAIN is entered.
//   Data, row and col are registered and held stable while valid && !ready.
//   A transfer occurs on valid && ready. Back-to-back transfers give 1 word/cycle.
//   row/col wrap col->0, row++ at OUT_DIM-1.
//   After the transfer of word N_OUT-1: o_rd_valid=0, o_done=1 for 1 cycle, state->IDLE.
//  i_en outside COLLECT: data dropped, buffer untouched, o_overflow:=1.
//  i_en in the same cycle that DRAIN is entered: dropped, o_overflow:=1.
//  i_start outside IDLE: ignored. o_busy=(state==COLLECT||state==DRAIN).
//  Async reset mid-operation: immediate return to reset values. The in-flight frame is
//   lost; the next frame needs a fresh i_start.
//  N_OUT==1 (FM_SIZE==KERNEL_SIZE, P=0): a single write goes straight to DRAIN.
// TESTING
//  1 K=1,FM=4,SHIFT=0: i_start, then 16 i_en beats with i_P=1..16 and ready=1
//    -> reads 1..16, row/col (0,0)..(3,3), o_done after word 16.
//  2 Saturation/ReLU, OUT_WIDTH=16: i_P=65536 -> 32767; i_P=-70000 -> -32768;
//    relu_en=1 with i_P=-5 -> 0; SHIFT=2 with i_P=-7 -> -2.
//  3 Backpressure: random i_rd_ready (~50%) during DRAIN -> no lost/duplicated words;
//    data, row and col stable while stalled.
//  4 Overflow: i_en=1 in IDLE -> o_overflow=1, no write. Next i_start clears it.
//    An extra beat during DRAIN also sets it and leaves the drained data unchanged.
//  5 Reset: assert i_rst_n=0 mid-DRAIN -> all outputs 0 asynchronously.
//    A new frame after release completes correctly.
//  6 K=FM=3: one beat i_P=42 -> single word 42 at (0,0), o_done pulse.

Source files
------------

// File: rtl/conv_result_writer.sv
// Collects PE results, then shifts, optionally ReLUs and saturates each into a frame buffer, and streams the frame out in raster order.
// Latency: one pipeline stage on capture; o_rd_valid rises one cycle after the last capture write; output is 1 word/cycle when unstalled.
// Backpressure: o_rd_* is held stable while o_rd_valid && !i_rd_ready; i_en has no backpressure, so excess beats are dropped and flagged.
module conv_result_writer #(
    parameter int KERNEL_SIZE = 3,
    parameter int FM_SIZE     = 4,
    parameter int PADDING     = 0,
    parameter int STRIDE      = 1,
    parameter int IN_WIDTH    = 48,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 0,
    localparam int OUT_DIM    = (FM_SIZE - KERNEL_SIZE + 2 * PADDING) / STRIDE + 1,
    localparam int RC_W       = (OUT_DIM > 1) ? $clog2(OUT_DIM) : 1
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic                        i_relu_en,
    input  logic                        i_en,
    input  logic signed [IN_WIDTH-1:0]  i_P,
    input  logic                        i_rd_ready,
    output logic                        o_rd_valid,
    output logic signed [OUT_WIDTH-1:0] o_rd_data,
    output logic [RC_W-1:0]             o_rd_row,
    output logic [RC_W-1:0]             o_rd_col,
    output logic                        o_busy,
    output logic                        o_done,
    output logic                        o_overflow
);

    localparam int N_OUT = OUT_DIM * OUT_DIM;
    localparam int CNT_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int DEPTH = 1 << CNT_W;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_OUT - 1);
    localparam logic [RC_W-1:0]  LAST_RC  = RC_W'(OUT_DIM - 1);

    localparam logic signed [IN_WIDTH-1:0] SAT_MAX =
        {{(IN_WIDTH - OUT_WIDTH + 1){1'b0}}, {(OUT_WIDTH - 1){1'b1}}};
    localparam logic signed [IN_WIDTH-1:0] SAT_MIN =
        {{(IN_WIDTH - OUT_WIDTH + 1){1'b1}}, {(OUT_WIDTH - 1){1'b0}}};

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_DRAIN   = 2'd2;

    logic [1:0]                  state;
    logic                        relu_q;
    logic [CNT_W-1:0]            wr_cnt;
    logic [CNT_W-1:0]            rd_cnt;
    logic                        rd_last;
    logic [RC_W-1:0]             nxt_row;
    logic [RC_W-1:0]             nxt_col;
    logic                        pipe_vld;
    logic signed [OUT_WIDTH-1:0] pipe_dat;
    logic signed [OUT_WIDTH-1:0] mem [DEPTH];

    logic signed [IN_WIDTH-1:0]  shifted;
    logic signed [IN_WIDTH-1:0]  clipped;
    logic signed [OUT_WIDTH-1:0] sat_dat;
    logic                        last_wr;
    logic                        accept;
    logic                        xfer;

    always_comb begin
        shifted = i_P >>> SHIFT;
        clipped = shifted;
        if (relu_q && shifted[IN_WIDTH-1]) begin
            clipped = '0;
        end
        sat_dat = clipped[OUT_WIDTH-1:0];
        if (clipped > SAT_MAX) begin
            sat_dat = SAT_MAX[OUT_WIDTH-1:0];
        end else if (clipped < SAT_MIN) begin
            sat_dat = SAT_MIN[OUT_WIDTH-1:0];
        end
    end

    // The cycle that commits the final write is already past the frame:
    // a beat arriving then would be word N_OUT+1, so it is refused.
    assign last_wr = pipe_vld && (wr_cnt == LAST_IDX);
    assign accept  = (state == ST_COLLECT) && !last_wr;
    assign xfer    = o_rd_valid && i_rd_ready;
    assign o_busy  = (state == ST_COLLECT) || (state == ST_DRAIN);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= ST_IDLE;
            relu_q     <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            rd_last    <= 1'b0;
            nxt_row    <= '0;
            nxt_col    <= '0;
            pipe_vld   <= 1'b0;
            pipe_dat   <= '0;
            o_rd_valid <= 1'b0;
            o_rd_data  <= '0;
            o_rd_row   <= '0;
            o_rd_col   <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            o_done   <= 1'b0;
            pipe_vld <= i_en && accept;
            if (i_en && accept) begin
                pipe_dat <= sat_dat;
            end

            case (state)
                ST_IDLE: begin
                    if (i_start) begin
                        state      <= ST_COLLECT;
                        wr_cnt     <= '0;
                        relu_q     <= i_relu_en;
                        o_overflow <= 1'b0;
                    end
                end
                ST_COLLECT: begin
                    if (pipe_vld) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (last_wr) begin
                            state   <= ST_DRAIN;
                            rd_cnt  <= '0;
                            rd_last <= 1'b0;
                            nxt_row <= '0;
                            nxt_col <= '0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (xfer && rd_last) begin
                        o_rd_valid <= 1'b0;
                        o_done     <= 1'b1;
                        rd_last    <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (!o_rd_valid || i_rd_ready) begin
                        o_rd_valid <= 1'b1;
                        o_rd_data  <= mem[rd_cnt];
                        o_rd_row   <= nxt_row;
                        o_rd_col   <= nxt_col;
                        rd_last    <= (rd_cnt == LAST_IDX);
                        rd_cnt     <= rd_cnt + 1'b1;
                        if (nxt_col == LAST_RC) begin
                            nxt_col <= '0;
                            nxt_row <= nxt_row + 1'b1;
                        end else begin
                            nxt_col <= nxt_col + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Placed after the start-clear so a dropped beat in the start cycle still flags.
            if (i_en && !accept) begin
                o_overflow <= 1'b1;
            end
        end
    end

    // Frame buffer needs no reset; contents are only read after a full frame is written.
    always_ff @(posedge i_clk) begin
        if (state == ST_COLLECT && pipe_vld) begin
            mem[wr_cnt] <= pipe_dat;
        end
    end

endmodule

// File: tb/tb_conv_result_writer.sv
module tb_conv_result_writer;

    logic clk;
    logic rst_n;

    // 4x4 output frame, SHIFT=0
    logic               start_a, relu_a, en_a, rdy_a;
    logic signed [47:0] p_a;
    logic               vld_a, busy_a, done_a, ovf_a;
    logic signed [15:0] dat_a;
    logic [1:0]         row_a, col_a;

    // Two single-word frames sharing stimulus: u1 SHIFT=2, u2 SHIFT=0
    logic               start_b, relu_b, en_b, rdy_b;
    logic signed [47:0] p_b;
    logic               vld_1, busy_1, done_1, ovf_1;
    logic signed [15:0] dat_1;
    logic [0:0]         row_1, col_1;
    logic               vld_2, busy_2, done_2, ovf_2;
    logic signed [15:0] dat_2;
    logic [0:0]         row_2, col_2;

    int n_cmp;
    int n_err;

    logic signed [47:0] stim [16];
    int exp_d [16];
    int got_d [16];
    int got_r [16];
    int got_c [16];
    int n_got, done_cnt, done_at, stall_bad, timed_out;

    conv_result_writer #(.KERNEL_SIZE(1), .FM_SIZE(4), .SHIFT(0)) u0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_a), .i_relu_en(relu_a),
        .i_en(en_a), .i_P(p_a), .i_rd_ready(rdy_a), .o_rd_valid(vld_a),
        .o_rd_data(dat_a), .o_rd_row(row_a), .o_rd_col(col_a), .o_busy(busy_a),
        .o_done(done_a), .o_overflow(ovf_a)
    );

    conv_result_writer #(.KERNEL_SIZE(1), .FM_SIZE(1), .SHIFT(2)) u1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_relu_en(relu_b),
        .i_en(en_b), .i_P(p_b), .i_rd_ready(rdy_b), .o_rd_valid(vld_1),
        .o_rd_data(dat_1), .o_rd_row(row_1), .o_rd_col(col_1), .o_busy(busy_1),
        .o_done(done_1), .o_overflow(ovf_1)
    );

    conv_result_writer #(.KERNEL_SIZE(3), .FM_SIZE(3), .SHIFT(0)) u2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start_b), .i_relu_en(relu_b),
        .i_en(en_b), .i_P(p_b), .i_rd_ready(rdy_b), .o_rd_valid(vld_2),
        .o_rd_data(dat_2), .o_rd_row(row_2), .o_rd_col(col_2), .o_busy(busy_2),
        .o_done(done_2), .o_overflow(ovf_2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_a_frame(input bit relu);
        start_a = 1'b1;
        relu_a  = relu;
        tick;
        start_a = 1'b0;
        relu_a  = ~relu;
    endtask

    task automatic send_a(input int gap);
        for (int i = 0; i < 16; i++) begin
            en_a = 1'b1;
            p_a  = stim[i];
            tick;
            en_a = 1'b0;
            repeat (gap) tick;
        end
    endtask

    // Captures accepted words until o_done; records stall-stability violations.
    task automatic drain_a(input bit rand_rdy);
        logic               p_vld, p_rdy;
        logic signed [15:0] p_dat;
        logic [1:0]         p_row, p_col;
        n_got = 0; done_cnt = 0; done_at = -1; stall_bad = 0; timed_out = 1;
        p_vld = 1'b0; p_rdy = 1'b0; p_dat = '0; p_row = '0; p_col = '0;
        for (int c = 0; c < 400; c++) begin
            rdy_a = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
            if (vld_a && rdy_a) begin
                if (n_got < 16) begin
                    got_d[n_got] = int'(dat_a);
                    got_r[n_got] = int'(row_a);
                    got_c[n_got] = int'(col_a);
                end
                n_got++;
            end
            p_vld = vld_a; p_rdy = rdy_a; p_dat = dat_a; p_row = row_a; p_col = col_a;
            tick;
            if (p_vld && !p_rdy &&
                (vld_a !== 1'b1 || dat_a !== p_dat || row_a !== p_row || col_a !== p_col))
                stall_bad++;
            if (done_a === 1'b1) begin
                done_cnt++;
                done_at   = n_got;
                timed_out = 0;
                break;
            end
        end
        rdy_a = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick;
        tick;
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", vld_a); end
        n_cmp++; if (dat_a !== 16'sd0) begin n_err++; $display("FAIL reset_data: got %0d want 0", dat_a); end
        n_cmp++; if (row_a !== 2'd0 || col_a !== 2'd0) begin n_err++; $display("FAIL reset_rowcol: got %0d,%0d want 0,0", row_a, col_a); end
        n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin n_err++; $display("FAIL reset_flags: got busy=%b done=%b ovf=%b want 0", busy_a, done_a, ovf_a); end
        n_cmp++; if (vld_1 !== 1'b0 || vld_2 !== 1'b0 || busy_1 !== 1'b0 || busy_2 !== 1'b0) begin n_err++; $display("FAIL reset_single: got vld=%b%b busy=%b%b want 0", vld_1, vld_2, busy_1, busy_2); end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_raster;
        for (int i = 0; i < 16; i++) begin stim[i] = i + 1; exp_d[i] = i + 1; end
        start_a_frame(1'b0);
        n_cmp++; if (busy_a !== 1'b1) begin n_err++; $display("FAIL raster_busy: got %b want 1", busy_a); end
        send_a(0);
        tick;
        n_cmp++; if (vld_a !== 1'b0) begin n_err++; $display("FAIL raster_valid_early: got %b want 0", vld_a); end
        tick;
        n_cmp++; if (vld_a !== 1'b1 || dat_a !== 16'sd1) begin n_err++; $display("FAIL raster_first_word: got vld=%b dat=%0d want 1,1", vld_a, dat_a); end
        drain_a(1'b0);
        n_cmp++; if (timed_out !== 0) begin n_err++; $display("FAIL raster_timeout: got no done want done"); end
        n_cmp++; if (n_got !== 16 || done_at !== 16) begin n_err++; $display("FAIL raster_count: got %0d words, done after %0d, want 16,16", n_got, done_at); end
        n_cmp++; if (vld_a !== 1'b0 || busy_a !== 1'b0) begin n_err++; $display("FAIL raster_end: got vld=%b busy=%b want 0,0", vld_a, busy_a); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_d[i] || got_r[i] !== i / 4 || got_c[i] !== i % 4) begin
                n_err++;
                $display("FAIL raster_word%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i, got_d[i], got_r[i], got_c[i], exp_d[i], i / 4, i % 4);
            end
        end
        tick;
        n_cmp++; if (done_a !== 1'b0) begin n_err++; $display("FAIL raster_done_pulse: got %b want 0", done_a); end
    endtask

    task automatic test_saturation;
        int v [16]   = '{65536, -70000, 32767, -32768, 32768, -32769, 5, -5, 0, -1, 1000, -1000, 0, 0, 12345, -12345};
        int e0 [16]  = '{32767, -32768, 32767, -32768, 32767, -32768, 5, -5, 0, -1, 1000, -1000, 32767, -32768, 12345, -12345};
        int e1 [16]  = '{32767, 0, 32767, 0, 32767, 0, 5, 0, 0, 0, 1000, 0, 32767, 0, 12345, 0};
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < 16; i++) begin
                stim[i]  = v[i];
                exp_d[i] = (f == 1) ? e1[i] : e0[i];
            end
            stim[12] = 48'sh7FFF_FFFF_FFFF;
            stim[13] = 48'sh8000_0000_0000;
            start_a_frame(f == 1);
            send_a(1 - f);
            drain_a(1'b0);
            n_cmp++; if (n_got !== 16 || timed_out !== 0) begin n_err++; $display("FAIL sat%0d_count: got %0d words timeout=%0d want 16,0", f, n_got, timed_out); end
            for (int i = 0; i < 16; i++) begin
                n_cmp++;
                if (got_d[i] !== exp_d[i]) begin n_err++; $display("FAIL sat%0d_word%0d: got %0d want %0d", f, i, got_d[i], exp_d[i]); end
            end
        end
        relu_a = 1'b0;
    endtask

    task automatic test_backpressure;
        for (int i = 0; i < 16; i++) begin stim[i] = i * 7 - 50; exp_d[i] = i * 7 - 50; end
        start_a_frame(1'b0);
        send_a(0);
        drain_a(1'b1);
        n_cmp++; if (timed_out !== 0 || n_got !== 16 || done_cnt !== 1) begin n_err++; $display("FAIL bp_count: got %0d words done=%0d timeout=%0d want 16,1,0", n_got, done_cnt, timed_out); end
        n_cmp++; if (stall_bad !== 0) begin n_err++; $display("FAIL bp_stable: got %0d unstable stalls want 0", stall_bad); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_d[i] || got_r[i] !== i / 4 || got_c[i] !== i % 4) begin
                n_err++;
                $display("FAIL bp_word%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i, got_d[i], got_r[i], got_c[i], exp_d[i], i / 4, i % 4);
            end
        end
    endtask

    task automatic test_overflow;
        en_a = 1'b1; p_a = 48'sd999; tick; en_a = 1'b0;
        n_cmp++; if (ovf_a !== 1'b1 || busy_a !== 1'b0 || vld_a !== 1'b0) begin n_err++; $display("FAIL ovf_idle: got ovf=%b busy=%b vld=%b want 1,0,0", ovf_a, busy_a, vld_a); end
        for (int i = 0; i < 16; i++) begin stim[i] = 300 - i * 11; exp_d[i] = 300 - i * 11; end
        start_a_frame(1'b0);
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL ovf_clear: got %b want 0", ovf_a); end
        send_a(0);
        n_cmp++; if (ovf_a !== 1'b0) begin n_err++; $display("FAIL ovf_frame: got %b want 0", ovf_a); end
        en_a = 1'b1; p_a = 48'sd777; tick; en_a = 1'b0;
        n_cmp++; if (ovf_a !== 1'b1 || busy_a !== 1'b1) begin n_err++; $display("FAIL ovf_drain_entry: got ovf=%b busy=%b want 1,1", ovf_a, busy_a); end
        tick;
        en_a = 1'b1; p_a = 48'sd555; tick; en_a = 1'b0;
        drain_a(1'b0);
        n_cmp++; if (n_got !== 16 || timed_out !== 0 || ovf_a !== 1'b1) begin n_err++; $display("FAIL ovf_drain: got %0d words timeout=%0d ovf=%b want 16,0,1", n_got, timed_out, ovf_a); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_d[i]) begin n_err++; $display("FAIL ovf_word%0d: got %0d want %0d", i, got_d[i], exp_d[i]); end
        end
    endtask

    task automatic test_async_reset;
        for (int i = 0; i < 16; i++) stim[i] = 200 + i;
        start_a_frame(1'b0);
        send_a(0);
        tick;
        tick;
        rdy_a = 1'b1;
        repeat (5) tick;
        rdy_a = 1'b0;
        n_cmp++; if (vld_a !== 1'b1 || dat_a !== 16'sd205 || row_a !== 2'd1 || col_a !== 2'd1) begin n_err++; $display("FAIL arst_pre: got vld=%b %0d@(%0d,%0d) want 1 205@(1,1)", vld_a, dat_a, row_a, col_a); end
        en_a = 1'b1; p_a = 48'sd1; tick; en_a = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (vld_a !== 1'b0 || dat_a !== 16'sd0 || row_a !== 2'd0 || col_a !== 2'd0) begin n_err++; $display("FAIL arst_data: got vld=%b %0d@(%0d,%0d) want 0 0@(0,0)", vld_a, dat_a, row_a, col_a); end
        n_cmp++; if (busy_a !== 1'b0 || done_a !== 1'b0 || ovf_a !== 1'b0) begin n_err++; $display("FAIL arst_flags: got busy=%b done=%b ovf=%b want 0", busy_a, done_a, ovf_a); end
        #2;
        rst_n = 1'b1;
        tick;
        for (int i = 0; i < 16; i++) begin stim[i] = -3 * i - 1; exp_d[i] = -3 * i - 1; end
        start_a_frame(1'b0);
        send_a(0);
        drain_a(1'b0);
        n_cmp++; if (n_got !== 16 || timed_out !== 0) begin n_err++; $display("FAIL arst_recover_count: got %0d words timeout=%0d want 16,0", n_got, timed_out); end
        for (int i = 0; i < 16; i++) begin
            n_cmp++;
            if (got_d[i] !== exp_d[i] || got_r[i] !== i / 4 || got_c[i] !== i % 4) begin
                n_err++;
                $display("FAIL arst_word%0d: got %0d@(%0d,%0d) want %0d@(%0d,%0d)", i, got_d[i], got_r[i], got_c[i], exp_d[i], i / 4, i % 4);
            end
        end
    endtask

    task automatic test_single(input int pv, input bit relu, input int e1, input int e2);
        bit seen;
        start_b = 1'b1; relu_b = relu; tick; start_b = 1'b0; relu_b = 1'b0;
        en_b = 1'b1; p_b = pv; tick; en_b = 1'b0;
        rdy_b = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (vld_2 === 1'b1) begin seen = 1'b1; break; end
            tick;
        end
        n_cmp++; if (seen !== 1'b1) begin n_err++; $display("FAIL single%0d_timeout: got no valid want valid", pv); end
        n_cmp++; if (vld_1 !== 1'b1 || int'(dat_1) !== e1) begin n_err++; $display("FAIL single%0d_shift2: got vld=%b %0d want 1 %0d", pv, vld_1, dat_1, e1); end
        n_cmp++; if (int'(dat_2) !== e2 || row_2 !== 1'b0 || col_2 !== 1'b0) begin n_err++; $display("FAIL single%0d_word: got %0d@(%0d,%0d) want %0d@(0,0)", pv, dat_2, row_2, col_2, e2); end
        tick;
        n_cmp++; if (done_1 !== 1'b1 || done_2 !== 1'b1 || vld_2 !== 1'b0) begin n_err++; $display("FAIL single%0d_done: got done=%b%b vld=%b want 11 0", pv, done_1, done_2, vld_2); end
        tick;
        n_cmp++; if (done_2 !== 1'b0 || busy_2 !== 1'b0) begin n_err++; $display("FAIL single%0d_idle: got done=%b busy=%b want 0,0", pv, done_2, busy_2); end
        rdy_b = 1'b0;
    endtask

    initial begin
        n_cmp = 0; n_err = 0;
        rst_n = 1'b0;
        start_a = 0; relu_a = 0; en_a = 0; rdy_a = 0; p_a = '0;
        start_b = 0; relu_b = 0; en_b = 0; rdy_b = 0; p_b = '0;
        test_reset;
        test_raster;
        test_saturation;
        test_backpressure;
        test_overflow;
        test_async_reset;
        test_single(42, 1'b0, 10, 42);
        test_single(-7, 1'b0, -2, -7);
        test_single(-5, 1'b1, 0, 0);
        test_single(200000, 1'b0, 32767, 32767);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
